// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types for the register-file write-back scheduler.
// The write-back request is the unit buffered by the load-return FIFO.
package regfile_wb_scheduler_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_WIDTH      = 32;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]      reg_data_t;

    typedef struct packed {
        reg_addr_t rd;
        reg_data_t wd;
    } wb_req_t;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_EXE  = 2'd1,
        GRANT_FIFO = 2'd2
    } grant_e;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the execute, load-issue, load-return, issue-stage and register-file
// signals around the write-back scheduler.
interface regfile_wb_scheduler_if;
    import regfile_wb_scheduler_pkg::*;

    // Handshakes are valid/ready: a transfer happens on a posedge where both are
    // high. valid never depends on ready; ready may depend on valid and state.
    logic      exe_valid;
    logic      exe_ready;
    reg_addr_t exe_rd;
    reg_data_t exe_wd;

    logic      ld_issue;
    reg_addr_t ld_issue_rd;
    logic      ld_issue_ready;

    logic      ld_valid;
    logic      ld_ready;
    reg_addr_t ld_rd;
    reg_data_t ld_wd;

    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      hazard;

    reg_addr_t rf_rd;
    reg_data_t rf_wd;
    logic      rf_we;

    modport master (
        output exe_valid, exe_rd, exe_wd,
        output ld_issue, ld_issue_rd,
        output ld_valid, ld_rd, ld_wd,
        output rs1, rs2,
        input  exe_ready, ld_issue_ready, ld_ready, hazard,
        input  rf_rd, rf_wd, rf_we
    );

    modport slave (
        input  exe_valid, exe_rd, exe_wd,
        input  ld_issue, ld_issue_rd,
        input  ld_valid, ld_rd, ld_wd,
        input  rs1, rs2,
        output exe_ready, ld_issue_ready, ld_ready, hazard,
        output rf_rd, rf_wd, rf_we
    );

endinterface

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// In-order synchronous FIFO of write-back requests, async active-low reset.
// Push is ignored when full and pop when empty.
module regfile_wb_scheduler_wb_fifo
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the register-file write port between execute results and buffered
// load returns, and tracks in-flight load destinations to flag RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int LQ_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_scheduler_if.slave bus
);

    localparam int ADDR_WIDTH = REG_ADDR_WIDTH;
    localparam int WIDTH      = REG_WIDTH;

    logic [NUM_REGS-1:0] pending_q, pending_d;

    wb_req_t          fifo_push_data;
    wb_req_t          fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    grant_e           grant;
    logic             exe_ok;
    logic             exe_ready;
    logic             ld_ready;
    logic             ld_issue_ready;
    logic             hazard;
    logic [ADDR_WIDTH-1:0] rf_rd;
    logic [WIDTH-1:0]      rf_wd;
    logic             rf_we;

    assign fifo_push_data.rd = bus.ld_rd;
    assign fifo_push_data.wd = bus.ld_wd;

    regfile_wb_scheduler_wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Every output is forced low while rst_n is asserted, not just the state.
    always_comb begin
        exe_ok         = !((bus.exe_rd != '0) && pending_q[bus.exe_rd]);
        ld_ready       = rst_n && !fifo_full;
        ld_issue_ready = rst_n && ((bus.ld_issue_rd == '0) || !pending_q[bus.ld_issue_rd]);
        hazard         = rst_n && (((bus.rs1 != '0) && pending_q[bus.rs1]) ||
                                   ((bus.rs2 != '0) && pending_q[bus.rs2]));
        fifo_push      = bus.ld_valid && ld_ready;
        grant          = GRANT_NONE;
        if (rst_n) begin
            if (fifo_full) begin
                grant = GRANT_FIFO;
            end else if (bus.exe_valid && exe_ok) begin
                grant = GRANT_EXE;
            end else if (!fifo_empty) begin
                grant = GRANT_FIFO;
            end
        end
    end

    always_comb begin
        exe_ready = 1'b0;
        fifo_pop  = 1'b0;
        rf_rd     = '0;
        rf_wd     = '0;
        rf_we     = 1'b0;
        case (grant)
            GRANT_EXE: begin
                exe_ready = 1'b1;
                rf_rd     = bus.exe_rd;
                rf_wd     = bus.exe_wd;
                rf_we     = (bus.exe_rd != '0);
            end
            GRANT_FIFO: begin
                fifo_pop = 1'b1;
                rf_rd    = fifo_head.rd;
                rf_wd    = fifo_head.wd;
                rf_we    = (fifo_head.rd != '0);
            end
            default: ;
        endcase
    end

    // Set and clear never target the same bit: issue is blocked while pending.
    always_comb begin
        pending_d = pending_q;
        if (fifo_pop && (fifo_head.rd != '0)) begin
            pending_d[fifo_head.rd] = 1'b0;
        end
        if (bus.ld_issue && ld_issue_ready && (bus.ld_issue_rd != '0)) begin
            pending_d[bus.ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.exe_ready      = exe_ready;
    assign bus.ld_ready       = ld_ready;
    assign bus.ld_issue_ready = ld_issue_ready;
    assign bus.hazard         = hazard;
    assign bus.rf_rd          = rf_rd;
    assign bus.rf_wd          = rf_wd;
    assign bus.rf_we          = rf_we;

endmodule
